// File: rtl/memshare_vn_iblut_rank_ctrl.sv
// memshare_vn_iblut_rank_ctrl
//   One information-bottleneck LUT per VN lane of a memory-share group.
//   Lookups: lane address = {column select, C2V message}, registered read,
//   1-cycle latency, 1 per cycle. GP1 lanes only own the lower half of the
//   column space, so the column-select MSB is masked off for them.
//   Reload: load_start_i enters LOAD, DEPTH valid&ready beats write one entry
//   per lane each at address wcnt, then DONE pulses for one cycle.
//   Lookups arriving while in LOAD are dropped and flagged on rd_drop_o.
//
// Ports
//   sys_clk, rst               clock, synchronous active-high reset
//   rd_valid_i                 lookup request
//   memShare_colSel_vec_i      lane i column select at [i*C +: C]
//   c2v_msg_vec_i              lane i C2V message at [i*Q +: Q]
//   v2c_msg_vec_o, v2c_valid_o lookup result (held while valid is low)
//   load_start_i               begin reload (honoured only in IDLE)
//   load_valid_i/load_ready_o  reload beat handshake
//   load_data_i                one entry per lane per beat
//   load_busy_o, load_done_o   reload in progress / one-cycle completion pulse
//   rd_drop_o                  one-cycle pulse: lookup discarded during reload

// Per-lane table: synchronous write, registered read; contents not reset.
module memshare_vn_iblut_lane #(
    parameter int QUAN_SIZE     = 4,
    parameter int COL_SEL_WIDTH = 2,
    parameter bit GP2           = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              we,
    input  logic [COL_SEL_WIDTH+QUAN_SIZE-1:0] waddr,
    input  logic [QUAN_SIZE-1:0]              wdata,
    input  logic                              re,
    input  logic [COL_SEL_WIDTH-1:0]          col_sel,
    input  logic [QUAN_SIZE-1:0]              c2v,
    output logic [QUAN_SIZE-1:0]              rdata
);
    localparam int AW    = COL_SEL_WIDTH + QUAN_SIZE;
    localparam int DEPTH = 1 << AW;
    // GP1 lanes see only 2^(C-1) columns: drop the column-select MSB.
    localparam logic [COL_SEL_WIDTH-1:0] COL_MASK =
        GP2 ? {COL_SEL_WIDTH{1'b1}} : ({COL_SEL_WIDTH{1'b1}} >> 1);

    logic [QUAN_SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]        raddr;
    logic                 wr_ok;

    assign raddr = {col_sel & COL_MASK, c2v};
    // Upper half of a GP1 lane is never addressed, so it is never written.
    assign wr_ok = GP2 || !waddr[AW-1];

    always_ff @(posedge clk) begin
        if (we && wr_ok) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

module memshare_vn_iblut_rank_ctrl #(
    parameter int SHARE_GROUP_SIZE = 4,
    parameter int QUAN_SIZE        = 4,
    parameter int COL_SEL_WIDTH    = 2,
    parameter logic [SHARE_GROUP_SIZE-1:0] GP_CONFIG = 4'b1010
) (
    input  logic                                  sys_clk,
    input  logic                                  rst,
    input  logic                                  rd_valid_i,
    input  logic [SHARE_GROUP_SIZE*COL_SEL_WIDTH-1:0] memShare_colSel_vec_i,
    input  logic [SHARE_GROUP_SIZE*QUAN_SIZE-1:0] c2v_msg_vec_i,
    output logic [SHARE_GROUP_SIZE*QUAN_SIZE-1:0] v2c_msg_vec_o,
    output logic                                  v2c_valid_o,
    input  logic                                  load_start_i,
    input  logic                                  load_valid_i,
    output logic                                  load_ready_o,
    input  logic [SHARE_GROUP_SIZE*QUAN_SIZE-1:0] load_data_i,
    output logic                                  load_busy_o,
    output logic                                  load_done_o,
    output logic                                  rd_drop_o
);
    localparam int N      = SHARE_GROUP_SIZE;
    localparam int Q      = QUAN_SIZE;
    localparam int C      = COL_SEL_WIDTH;
    localparam int AW     = C + Q;
    localparam int STAGES = 1;
    localparam logic [AW-1:0] WCNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state, state_nx;
    logic [AW-1:0]     wcnt;
    logic              beat;
    logic              rd_acc;
    logic [STAGES:1]   vld_pipe;

    assign beat   = load_valid_i && load_ready_o;
    assign rd_acc = rd_valid_i && (state != LOAD);

    // State register and beat counter
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && load_start_i) wcnt <= '0;
            else if (beat)                     wcnt <= wcnt + 1'b1;
        end
    end

    // Next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (load_start_i) state_nx = LOAD;
            LOAD:    if (beat && wcnt == WCNT_LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        load_ready_o = 1'b0;
        load_busy_o  = 1'b0;
        load_done_o  = 1'b0;
        case (state)
            LOAD: begin
                load_ready_o = 1'b1;
                load_busy_o  = 1'b1;
            end
            DONE:    load_done_o = 1'b1;
            default: ;
        endcase
    end

    // Read valid / drop flags, aligned with the registered LUT read
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            vld_pipe  <= '0;
            rd_drop_o <= 1'b0;
        end else begin
            vld_pipe  <= STAGES'(rd_acc);
            rd_drop_o <= rd_valid_i && (state == LOAD);
        end
    end
    assign v2c_valid_o = vld_pipe[STAGES];

    for (genvar i = 0; i < N; i++) begin : g_lane
        memshare_vn_iblut_lane #(
            .QUAN_SIZE    (Q),
            .COL_SEL_WIDTH(C),
            .GP2          (GP_CONFIG[i])
        ) u_lane (
            .clk    (sys_clk),
            .rst    (rst),
            .we     (beat),
            .waddr  (wcnt),
            .wdata  (load_data_i[i*Q +: Q]),
            .re     (rd_acc),
            .col_sel(memShare_colSel_vec_i[i*C +: C]),
            .c2v    (c2v_msg_vec_i[i*Q +: Q]),
            .rdata  (v2c_msg_vec_o[i*Q +: Q])
        );
    end
endmodule

// File: tb/tb_memshare_vn_iblut_rank_ctrl.sv
module tb_memshare_vn_iblut_rank_ctrl;
    localparam int N = 4;
    localparam int Q = 4;
    localparam int C = 2;
    localparam logic [N-1:0] GP = 4'b1010;
    localparam int DEPTH = 1 << (C + Q);

    logic           sys_clk = 1'b0;
    logic           rst = 1'b1;
    logic           rd_valid = 1'b0;
    logic [N*C-1:0] col_sel = '0;
    logic [N*Q-1:0] c2v = '0;
    logic [N*Q-1:0] v2c_msg;
    logic           v2c_valid;
    logic           load_start = 1'b0;
    logic           load_valid = 1'b0;
    logic           load_ready;
    logic [N*Q-1:0] load_data = '0;
    logic           load_busy;
    logic           load_done;
    logic           rd_drop;

    int total = 0;
    int bad   = 0;

    // Reference table contents per lane, indexed by full lane address.
    logic [Q-1:0] ref_lut [N][DEPTH];

    memshare_vn_iblut_rank_ctrl #(
        .SHARE_GROUP_SIZE(N), .QUAN_SIZE(Q), .COL_SEL_WIDTH(C), .GP_CONFIG(GP)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .rd_valid_i(rd_valid),
        .memShare_colSel_vec_i(col_sel), .c2v_msg_vec_i(c2v),
        .v2c_msg_vec_o(v2c_msg), .v2c_valid_o(v2c_valid),
        .load_start_i(load_start), .load_valid_i(load_valid),
        .load_ready_o(load_ready), .load_data_i(load_data),
        .load_busy_o(load_busy), .load_done_o(load_done), .rd_drop_o(rd_drop)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    // Expected lookup: GP1 lanes only use the low C-1 column bits.
    function automatic logic [N*Q-1:0] exp_vec(logic [N*C-1:0] cs, logic [N*Q-1:0] cv);
        logic [N*Q-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            int col, addr;
            col = int'(cs[i*C +: C]);
            if (!GP[i]) col = col % (1 << (C - 1));
            addr = col * (1 << Q) + int'(cv[i*Q +: Q]);
            r[i*Q +: Q] = ref_lut[i][addr];
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++; if (v2c_msg !== '0)     begin bad++; $display("FAIL rst_msg got=%h want=0", v2c_msg); end
        total++; if (v2c_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", v2c_valid); end
        total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", load_ready); end
        total++; if (load_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", load_busy); end
        total++; if (load_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", load_done); end
        total++; if (rd_drop !== 1'b0)   begin bad++; $display("FAIL rst_drop got=%b want=0", rd_drop); end
        rst = 1'b0;
        load_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            load_data = N*Q'($urandom);
            step();
            total++;
            if (load_ready !== 1'b0 || load_busy !== 1'b0) begin
                bad++; $display("FAIL idle_ready cyc=%0d got ready=%b busy=%b want 0/0", k, load_ready, load_busy);
            end
        end
        load_valid = 1'b0;
    endtask

    // One reload. drop_at / restart_at / rst_at select a beat index at which
    // to inject a lookup, a second load_start, or a reset (-1 = never).
    task automatic do_reload(input bit rnd, input int drop_at, input int restart_at,
                             input int rst_at, input bit rd_with_start);
        logic [N*Q-1:0] d, expv;
        int beat;
        expv = '0;
        load_start = 1'b1;
        if (rd_with_start) begin
            rd_valid = 1'b1;
            col_sel  = N*C'($urandom);
            c2v      = N*Q'($urandom);
            expv     = exp_vec(col_sel, c2v);
        end
        step();
        load_start = 1'b0;
        rd_valid   = 1'b0;
        total++;
        if (load_ready !== 1'b1 || load_busy !== 1'b1) begin
            bad++; $display("FAIL start_ready got ready=%b busy=%b want 1/1", load_ready, load_busy);
        end
        if (rd_with_start) begin
            total++;
            if (v2c_valid !== 1'b1 || v2c_msg !== expv) begin
                bad++; $display("FAIL rd_with_start got v=%b d=%h want v=1 d=%h", v2c_valid, v2c_msg, expv);
            end
        end
        beat = 0;
        while (beat < DEPTH) begin
            if (beat == rst_at) begin
                load_valid = 1'b0;
                rst = 1'b1;
                step();
                rst = 1'b0;
                total++;
                if (load_busy !== 1'b0 || load_ready !== 1'b0 || load_done !== 1'b0 ||
                    v2c_valid !== 1'b0 || rd_drop !== 1'b0 || v2c_msg !== '0) begin
                    bad++; $display("FAIL mid_rst got busy=%b ready=%b done=%b v=%b drop=%b d=%h want all 0",
                                    load_busy, load_ready, load_done, v2c_valid, rd_drop, v2c_msg);
                end
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                load_valid = 1'b0;
                load_data  = N*Q'($urandom);
                step();
                total++;
                if (load_busy !== 1'b1 || load_done !== 1'b0) begin
                    bad++; $display("FAIL gap_state beat=%0d got busy=%b done=%b want 1/0", beat, load_busy, load_done);
                end
                continue;
            end
            for (int i = 0; i < N; i++)
                d[i*Q +: Q] = rnd ? Q'($urandom) : Q'((beat + i) % 16);
            load_data  = d;
            load_valid = 1'b1;
            if (beat == drop_at) begin
                rd_valid = 1'b1;
                col_sel  = N*C'($urandom);
                c2v      = N*Q'($urandom);
            end
            if (beat == restart_at) load_start = 1'b1;
            step();
            for (int i = 0; i < N; i++)
                if (GP[i] || beat < DEPTH / 2) ref_lut[i][beat] = d[i*Q +: Q];
            rd_valid   = 1'b0;
            load_start = 1'b0;
            if (beat == drop_at) begin
                total++;
                if (rd_drop !== 1'b1 || v2c_valid !== 1'b0) begin
                    bad++; $display("FAIL drop got drop=%b v=%b want 1/0", rd_drop, v2c_valid);
                end
            end
            beat++;
            if (beat < DEPTH) begin
                total++;
                if (load_done !== 1'b0 || load_busy !== 1'b1) begin
                    bad++; $display("FAIL mid_load beat=%0d got done=%b busy=%b want 0/1", beat, load_done, load_busy);
                end
            end
        end
        load_valid = 1'b0;
        total++;
        if (load_done !== 1'b1 || load_busy !== 1'b0 || load_ready !== 1'b0) begin
            bad++; $display("FAIL done_pulse got done=%b busy=%b ready=%b want 1/0/0", load_done, load_busy, load_ready);
        end
        step();
        total++;
        if (load_done !== 1'b0 || load_busy !== 1'b0) begin
            bad++; $display("FAIL done_single got done=%b busy=%b want 0/0", load_done, load_busy);
        end
    endtask

    // Back-to-back sweep of every (column, message) pair, same on all lanes.
    task automatic test_lookup_all(input string tag);
        logic [N*Q-1:0] expv;
        expv = '0;
        rd_valid = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            for (int i = 0; i < N; i++) begin
                col_sel[i*C +: C] = C'(a >> Q);
                c2v[i*Q +: Q]     = Q'(a);
            end
            expv = exp_vec(col_sel, c2v);
            step();
            total++;
            if (v2c_valid !== 1'b1 || v2c_msg !== expv) begin
                bad++; $display("FAIL %s addr=%0d got v=%b d=%h want v=1 d=%h", tag, a, v2c_valid, v2c_msg, expv);
            end
        end
        rd_valid = 1'b0;
        step();
        total++;
        if (v2c_valid !== 1'b0 || v2c_msg !== expv) begin
            bad++; $display("FAIL %s_hold got v=%b d=%h want v=0 d=%h", tag, v2c_valid, v2c_msg, expv);
        end
    endtask

    task automatic test_full_reload();
        do_reload(1'b0, -1, -1, -1, 1'b0);
    endtask

    task automatic test_fixed_lookup();
        logic [N*Q-1:0] expv;
        col_sel = {N{2'b11}};
        c2v     = {N{4'h5}};
        expv    = exp_vec(col_sel, c2v);
        rd_valid = 1'b1;
        step();
        rd_valid = 1'b0;
        total++;
        if (v2c_valid !== 1'b1 || v2c_msg !== expv) begin
            bad++; $display("FAIL fixed_lookup got v=%b d=%h want v=1 d=%h", v2c_valid, v2c_msg, expv);
        end
        step();
        total++;
        if (v2c_valid !== 1'b0) begin bad++; $display("FAIL fixed_lookup_end got v=%b want 0", v2c_valid); end
    endtask

    // Beats outside LOAD must not write: sweep the whole table afterwards.
    task automatic test_idle_ignore();
        load_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            load_data = N*Q'($urandom);
            step();
        end
        load_valid = 1'b0;
        test_lookup_all("idle_ignore");
    endtask

    task automatic test_back_to_back();
        logic [N*Q-1:0] expq [$];
        logic [N*Q-1:0] expv;
        rd_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            col_sel = N*C'($urandom);
            c2v     = N*Q'($urandom);
            expq.push_back(exp_vec(col_sel, c2v));
            step();
            expv = expq.pop_front();
            total++;
            if (v2c_valid !== 1'b1 || v2c_msg !== expv) begin
                bad++; $display("FAIL b2b k=%0d got v=%b d=%h want v=1 d=%h", k, v2c_valid, v2c_msg, expv);
            end
        end
        rd_valid = 1'b0;
        step();
        total++;
        if (v2c_valid !== 1'b0) begin bad++; $display("FAIL b2b_end got v=%b want 0", v2c_valid); end
    endtask

    task automatic test_read_during_load();
        do_reload(1'b1, 10, 30, -1, 1'b1);
        test_lookup_all("after_drop");
    endtask

    task automatic test_reset_mid_load();
        do_reload(1'b1, -1, -1, 20, 1'b0);
        do_reload(1'b1, -1, -1, -1, 1'b0);
        test_lookup_all("after_rst_reload");
    endtask

    initial begin
        test_reset();
        test_full_reload();
        test_fixed_lookup();
        test_idle_ignore();
        test_back_to_back();
        test_read_during_load();
        test_reset_mid_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
